lanectrl_delay_tap_sequencer: RTL and testbench

- Sequences the DQS delay-line control pins of one DDR4 lane controller (DELAY_LINE_SEL/LOAD/DIRECTION/MOVE, HS_IO_CLK_PAUSE).
- Training logic issues move, load and abort-safe requests through a valid/ready port.
- Serialises the requests into correctly spaced tap pulses, wraps TX moves in an HS_IO_CLK pause window and tracks RX and TX tap positions.
- Sits between the PHY training FSM and the lane controller wrapper; all logic on FAB_CLK.

---
 rtl/lanectrl_delay_tap_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_lanectrl_delay_tap_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lanectrl_delay_tap_sequencer.sv
// lanectrl_delay_tap_sequencer
// Turns move/load requests from the PHY training FSM into spaced DQS
// delay-line pulses for one DDR4 lane, wraps TX line activity in an
// HS_IO_CLK pause window and tracks the RX and TX tap positions.
//
// Handshake: a request transfers on a FAB_CLK edge where REQ_VALID and
// REQ_READY are both 1; REQ_READY is 1 only in IDLE (and never while
// RESET_N is low), REQ_* are captured on that edge and REQ_VALID may drop
// afterwards. Completion is a single-cycle DONE, with DONE_ERR valid alongside.
module lanectrl_delay_tap_sequencer #(
    parameter int TAP_W       = 8,
    parameter int MAX_TAP     = 255,
    parameter int LOAD_VAL    = 1,
    parameter int MOVE_GAP    = 3,
    parameter int PAUSE_SETUP = 2,
    parameter int PAUSE_HOLD  = 2
) (
    input  logic             FAB_CLK,
    input  logic             RESET_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_OP,
    input  logic             REQ_LINE,
    input  logic             REQ_DIR,
    input  logic [TAP_W-1:0] REQ_COUNT,
    output logic             DONE,
    output logic             DONE_ERR,
    output logic [TAP_W-1:0] RX_TAP,
    output logic [TAP_W-1:0] TX_TAP,
    output logic             DELAY_LINE_SEL,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_DIRECTION,
    output logic             DELAY_LINE_MOVE,
    output logic             HS_IO_CLK_PAUSE,
    input  logic             RX_DELAY_LINE_OUT_OF_RANGE,
    input  logic             TX_DELAY_LINE_OUT_OF_RANGE,
    output logic [2:0]       STATE_DBG
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PAUSE_PRE  = 3'd1,
        LOAD       = 3'd2,
        MOVE       = 3'd3,
        GAP        = 3'd4,
        PAUSE_POST = 3'd5,
        RESP       = 3'd6
    } state_t;

    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_LOAD = TAP_W'(LOAD_VAL);
    localparam logic [3:0]       GAP_LAST  = 4'(MOVE_GAP - 1);
    localparam logic [3:0]       SETUP_LAST = 4'(PAUSE_SETUP - 1);
    localparam logic [3:0]       HOLD_LAST  = 4'(PAUSE_HOLD - 1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [TAP_W-1:0] rem_q, rem_d;
    logic             err_q, err_d;
    logic             line_q, line_d;
    logic             dir_q, dir_d;
    logic             op_q, op_d;
    logic [TAP_W-1:0] rx_tap_q, rx_tap_d;
    logic [TAP_W-1:0] tx_tap_q, tx_tap_d;

    // Request view used by the "what happens next" decision: live inputs
    // while accepting in IDLE, captured fields everywhere else.
    logic             sel_op, sel_line, sel_dir;
    logic [TAP_W-1:0] sel_count, sel_tap;
    logic             blocked;
    state_t           finish_st, step_st;
    logic             step_err;
    logic             req_fire;
    logic             oor_sel;

    assign req_fire = REQ_VALID & REQ_READY;
    assign oor_sel  = line_q ? TX_DELAY_LINE_OUT_OF_RANGE : RX_DELAY_LINE_OUT_OF_RANGE;

    // Decide the next work step: load, next tap pulse, or wrap-up (with the
    // range check that stops a pulse which would run the tap off either end).
    always_comb begin
        sel_op    = (state_q == IDLE) ? REQ_OP    : op_q;
        sel_line  = (state_q == IDLE) ? REQ_LINE  : line_q;
        sel_dir   = (state_q == IDLE) ? REQ_DIR   : dir_q;
        sel_count = (state_q == IDLE) ? REQ_COUNT : rem_q;
        sel_tap   = sel_line ? tx_tap_q : rx_tap_q;
        blocked   = sel_dir ? (sel_tap == TAP_MAX) : (sel_tap == '0);
        finish_st = sel_line ? PAUSE_POST : RESP;
        step_err  = 1'b0;
        if (sel_op) begin
            step_st = LOAD;
        end else if (sel_count == '0) begin
            step_st = finish_st;
        end else if (blocked) begin
            step_st  = finish_st;
            step_err = 1'b1;
        end else begin
            step_st = MOVE;
        end
    end

    // Next-state, counters and tap tracking.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        err_d    = err_q;
        line_d   = line_q;
        dir_d    = dir_q;
        op_d     = op_q;
        rx_tap_d = rx_tap_q;
        tx_tap_d = tx_tap_q;
        case (state_q)
            IDLE: begin
                if (req_fire) begin
                    line_d = REQ_LINE;
                    dir_d  = REQ_DIR;
                    op_d   = REQ_OP;
                    rem_d  = REQ_COUNT;
                    if (REQ_LINE) begin
                        state_d = PAUSE_PRE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = step_st;
                        err_d   = step_err;
                    end
                end
            end
            PAUSE_PRE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = step_st;
                    err_d   = err_q | step_err;
                end
            end
            LOAD: begin
                if (line_q) tx_tap_d = TAP_LOAD;
                else        rx_tap_d = TAP_LOAD;
                state_d = line_q ? PAUSE_POST : RESP;
            end
            MOVE: begin
                if (line_q) begin
                    if (dir_q && tx_tap_q != TAP_MAX)      tx_tap_d = tx_tap_q + 1'b1;
                    else if (!dir_q && tx_tap_q != '0)     tx_tap_d = tx_tap_q - 1'b1;
                end else begin
                    if (dir_q && rx_tap_q != TAP_MAX)      rx_tap_d = rx_tap_q + 1'b1;
                    else if (!dir_q && rx_tap_q != '0)     rx_tap_d = rx_tap_q - 1'b1;
                end
                rem_d   = rem_q - 1'b1;
                state_d = GAP;
            end
            GAP: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    if (oor_sel) begin
                        // Lane reports the line ran out: drop remaining taps,
                        // keep the counted position.
                        err_d   = 1'b1;
                        rem_d   = '0;
                        state_d = line_q ? PAUSE_POST : RESP;
                    end else begin
                        state_d = step_st;
                        err_d   = err_q | step_err;
                    end
                end
            end
            PAUSE_POST: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = RESP;
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Timed states start their countdown on entry.
        if (state_d != state_q) begin
            case (state_d)
                PAUSE_PRE:  cnt_d = SETUP_LAST;
                GAP:        cnt_d = GAP_LAST;
                PAUSE_POST: cnt_d = HOLD_LAST;
                default:    cnt_d = cnt_d;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge FAB_CLK) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
            line_q   <= 1'b0;
            dir_q    <= 1'b0;
            op_q     <= 1'b0;
            rx_tap_q <= TAP_LOAD;
            tx_tap_q <= TAP_LOAD;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            err_q    <= err_d;
            line_q   <= line_d;
            dir_q    <= dir_d;
            op_q     <= op_d;
            rx_tap_q <= rx_tap_d;
            tx_tap_q <= tx_tap_d;
        end
    end

    // Lane-facing outputs decode straight from the registered state.
    always_comb begin
        REQ_READY            = (state_q == IDLE) & RESET_N;
        DONE                 = (state_q == RESP);
        DONE_ERR             = (state_q == RESP) & err_q;
        DELAY_LINE_LOAD      = (state_q == LOAD);
        DELAY_LINE_MOVE      = (state_q == MOVE);
        DELAY_LINE_SEL       = (state_q != IDLE) & line_q;
        DELAY_LINE_DIRECTION = (state_q != IDLE) & dir_q;
        HS_IO_CLK_PAUSE      = line_q & (state_q != IDLE) & (state_q != RESP);
        RX_TAP               = rx_tap_q;
        TX_TAP               = tx_tap_q;
        STATE_DBG            = state_q;
    end

endmodule

// File: tb/tb_lanectrl_delay_tap_sequencer.sv
// Directed bench for lanectrl_delay_tap_sequencer with default parameters
// (MOVE_GAP=3, PAUSE_SETUP=2, PAUSE_HOLD=2, LOAD_VAL=1). Cycle 0 is the
// acceptance cycle; per-cycle output traces are compared to hand-built masks.
module tb_lanectrl_delay_tap_sequencer;

  logic       FAB_CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic       REQ_READY;
  logic       REQ_OP = 1'b0;
  logic       REQ_LINE = 1'b0;
  logic       REQ_DIR = 1'b0;
  logic [7:0] REQ_COUNT = 8'd0;
  logic       DONE, DONE_ERR;
  logic [7:0] RX_TAP, TX_TAP;
  logic       DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE;
  logic       HS_IO_CLK_PAUSE;
  logic       RX_OOR = 1'b0;
  logic       TX_OOR = 1'b0;
  logic [2:0] STATE_DBG;

  lanectrl_delay_tap_sequencer dut (
    .FAB_CLK                    (FAB_CLK),
    .RESET_N                    (RESET_N),
    .REQ_VALID                  (REQ_VALID),
    .REQ_READY                  (REQ_READY),
    .REQ_OP                     (REQ_OP),
    .REQ_LINE                   (REQ_LINE),
    .REQ_DIR                    (REQ_DIR),
    .REQ_COUNT                  (REQ_COUNT),
    .DONE                       (DONE),
    .DONE_ERR                   (DONE_ERR),
    .RX_TAP                     (RX_TAP),
    .TX_TAP                     (TX_TAP),
    .DELAY_LINE_SEL             (DELAY_LINE_SEL),
    .DELAY_LINE_LOAD            (DELAY_LINE_LOAD),
    .DELAY_LINE_DIRECTION       (DELAY_LINE_DIRECTION),
    .DELAY_LINE_MOVE            (DELAY_LINE_MOVE),
    .HS_IO_CLK_PAUSE            (HS_IO_CLK_PAUSE),
    .RX_DELAY_LINE_OUT_OF_RANGE (RX_OOR),
    .TX_DELAY_LINE_OUT_OF_RANGE (TX_OOR),
    .STATE_DBG                  (STATE_DBG)
  );

  // clock / watchdog
  always #5 FAB_CLK = ~FAB_CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] mv_tr, ld_tr, pz_tr, sel_tr, dir_tr;
  logic        ovl;
  int          done_cyc;
  logic        err_at_done, done_after, rdy_after;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request for its acceptance cycle; returns at negedge of cycle 1.
  task automatic send(input logic op, input logic line, input logic dir, input logic [7:0] cnt);
    REQ_OP = op; REQ_LINE = line; REQ_DIR = dir; REQ_COUNT = cnt;
    REQ_VALID = 1'b1;
    @(negedge FAB_CLK);
    REQ_VALID = 1'b0;
    REQ_OP = $urandom_range(0, 1); REQ_LINE = $urandom_range(0, 1);
    REQ_DIR = $urandom_range(0, 1); REQ_COUNT = 8'($urandom_range(0, 255));
  endtask

  // Trace outputs per cycle until DONE (bounded); TX_OOR rises at oor_cyc.
  task automatic run(input int oor_cyc);
    mv_tr = '0; ld_tr = '0; pz_tr = '0; sel_tr = '0; dir_tr = '0;
    ovl = 1'b0; done_cyc = -1; err_at_done = 1'b0;
    for (int c = 1; c < 64; c++) begin
      if (c == oor_cyc) TX_OOR = 1'b1;
      mv_tr[c]  = DELAY_LINE_MOVE;
      ld_tr[c]  = DELAY_LINE_LOAD;
      pz_tr[c]  = HS_IO_CLK_PAUSE;
      sel_tr[c] = DELAY_LINE_SEL;
      dir_tr[c] = DELAY_LINE_DIRECTION;
      ovl = ovl | (DELAY_LINE_MOVE & DELAY_LINE_LOAD);
      if (DONE) begin
        done_cyc = c;
        err_at_done = DONE_ERR;
        break;
      end
      @(negedge FAB_CLK);
    end
    @(negedge FAB_CLK);
    done_after = DONE;
    rdy_after = REQ_READY;
    TX_OOR = 1'b0;
  endtask

  task automatic op_req(input logic op, input logic line, input logic dir, input logic [7:0] cnt,
                        input int oor_cyc);
    send(op, line, dir, cnt);
    run(oor_cyc);
  endtask

  logic [7:0] outs;
  logic       seen_done;

  initial begin
    // reset
    RESET_N = 1'b0;
    repeat (3) @(negedge FAB_CLK);
    chk("rst_ready", REQ_READY, 1'b0);
    chk("rst_rx_tap", RX_TAP, 8'd1);
    chk("rst_tx_tap", TX_TAP, 8'd1);
    chk("rst_outs", {DONE, DONE_ERR, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION,
                     DELAY_LINE_MOVE, HS_IO_CLK_PAUSE}, 7'd0);
    RESET_N = 1'b1;
    @(negedge FAB_CLK);
    chk("post_rst_ready", REQ_READY, 1'b1);

    // RX move up 4
    op_req(1'b0, 1'b0, 1'b1, 8'd4, 0);
    chk("rx4_move", mv_tr, 64'h2222);
    chk("rx4_done", done_cyc, 17);
    chk("rx4_err", err_at_done, 1'b0);
    chk("rx4_pause", pz_tr, 64'h0);
    chk("rx4_load", ld_tr, 64'h0);
    chk("rx4_sel", sel_tr, 64'h0);
    chk("rx4_dir", dir_tr, 64'h3FFFE);
    chk("rx4_tap", RX_TAP, 8'd5);
    chk("rx4_done_once", done_after, 1'b0);
    chk("rx4_ready_after", rdy_after, 1'b1);

    // TX move up 3
    op_req(1'b0, 1'b1, 1'b1, 8'd3, 0);
    chk("tx3_move", mv_tr, 64'h888);
    chk("tx3_pause", pz_tr, 64'h1FFFE);
    chk("tx3_sel", sel_tr, 64'h3FFFE);
    chk("tx3_done", done_cyc, 17);
    chk("tx3_tap", TX_TAP, 8'd4);
    chk("tx3_rx_untouched", RX_TAP, 8'd5);

    // TX load
    op_req(1'b1, 1'b1, 1'b0, 8'd9, 0);
    chk("txld_pause", pz_tr, 64'h3E);
    chk("txld_load", ld_tr, 64'h8);
    chk("txld_move", mv_tr, 64'h0);
    chk("txld_done", done_cyc, 6);
    chk("txld_err", err_at_done, 1'b0);
    chk("txld_tap", TX_TAP, 8'd1);
    chk("txld_pause_after", HS_IO_CLK_PAUSE, 1'b0);

    // RX load then RX move down 5 hits the lower limit
    op_req(1'b1, 1'b0, 1'b1, 8'd0, 0);
    chk("rxld_load", ld_tr, 64'h2);
    chk("rxld_done", done_cyc, 2);
    chk("rxld_tap", RX_TAP, 8'd1);
    op_req(1'b0, 1'b0, 1'b0, 8'd5, 0);
    chk("rxdn_move", mv_tr, 64'h2);
    chk("rxdn_done", done_cyc, 5);
    chk("rxdn_err", err_at_done, 1'b1);
    chk("rxdn_tap", RX_TAP, 8'd0);
    chk("rxdn_dir", dir_tr, 64'h0);

    // TX move up 10 aborted by out-of-range after 2nd pulse
    op_req(1'b0, 1'b1, 1'b1, 8'd10, 8);
    chk("txoor_move", mv_tr, 64'h88);
    chk("txoor_done", done_cyc, 13);
    chk("txoor_err", err_at_done, 1'b1);
    chk("txoor_pause", pz_tr, 64'h1FFE);
    chk("txoor_tap", TX_TAP, 8'd3);

    // count 0 on each line
    op_req(1'b0, 1'b0, 1'b1, 8'd0, 0);
    chk("rx0_done", done_cyc, 1);
    chk("rx0_pulses", mv_tr | ld_tr, 64'h0);
    chk("rx0_err", err_at_done, 1'b0);
    op_req(1'b0, 1'b1, 1'b1, 8'd0, 0);
    chk("tx0_done", done_cyc, 5);
    chk("tx0_pulses", mv_tr | ld_tr, 64'h0);
    chk("tx0_pause", pz_tr, 64'h1E);
    chk("tx0_err", err_at_done, 1'b0);
    chk("tx0_tap", TX_TAP, 8'd3);

    // reset during 2nd GAP of an RX move up 4 (RX_TAP starts at 0)
    send(1'b0, 1'b0, 1'b1, 8'd4);
    repeat (6) @(negedge FAB_CLK);
    chk("rstmid_tap_before", RX_TAP, 8'd2);
    RESET_N = 1'b0;
    @(negedge FAB_CLK);
    outs = {DONE, DONE_ERR, DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION,
            DELAY_LINE_MOVE, HS_IO_CLK_PAUSE, REQ_READY};
    chk("rstmid_outs", outs, 8'd0);
    chk("rstmid_rx_tap", RX_TAP, 8'd1);
    chk("rstmid_tx_tap", TX_TAP, 8'd1);
    repeat (2) @(negedge FAB_CLK);
    RESET_N = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen_done = seen_done | DONE;
      @(negedge FAB_CLK);
    end
    chk("rstmid_no_done", seen_done, 1'b0);
    chk("rstmid_ready", REQ_READY, 1'b1);
    op_req(1'b0, 1'b0, 1'b1, 8'd2, 0);
    chk("after_rst_move", mv_tr, 64'h22);
    chk("after_rst_done", done_cyc, 9);
    chk("after_rst_tap", RX_TAP, 8'd3);
    chk("after_rst_overlap", ovl, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
